sw_out_arb: RTL and testbench
=============================

# sw_out_arb

Output-port reader for the switch. It drains up to N per-input packet FIFOs that share one output port, arbitrating round-robin among FIFOs whose head packet is addressed to this port. Selected packets are forwarded through a one-entry output register with a valid/ready handshake toward the link. It is the consumer side of the switch FIFO interface (`out`/`empty` in, `re` out) and keeps a count of forwarded packets.

## Interface
Parameters:
- N, 4: number of input FIFOs (2..8).
- PORT_ID, 0: destination value this output port accepts.
- DSTW, 2: width of the destination field. The field occupies packet bits [`PKTW : `PKTW-DSTW+1].
- CNTW, 16: width of the forwarded-packet counter.

Ports:
- clk, in, 1: single clock; all state updates on posedge.
- rst, in, 1: asynchronous, active-high reset.
- fifo_out, in, N*(`PKTW+1): head packets of the FIFOs, concatenated; FIFO i uses slice i.
- fifo_empty, in, N: per-FIFO empty flag; the head slice is valid only when this flag is low.
- fifo_re, out, N: per-FIFO pop strobe; the FIFO advances its tail at the next posedge.
- pkt_out, out, `PKTW+1: forwarded packet.
- pkt_valid, out, 1: pkt_out holds a packet.
- pkt_ready, in, 1: downstream accepts pkt_out in this cycle.
- pkt_cnt, out, CNTW: number of packets accepted downstream; wraps modulo 2^CNTW.

## Operation
- Request: req[i] = !fifo_empty[i] && (dst field of fifo_out slice i == PORT_ID). A FIFO whose head is addressed elsewhere is skipped and never popped by this block.
- Load enable: load_ok = !pkt_valid || pkt_ready. The output register either is empty or is being drained this cycle.
- Grant: when load_ok and any req is set, grant the first set req at or after rr_ptr, scanning upward with wrap from N-1 to 0.
  - fifo_re is one-hot on the granted index; otherwise it is all zero.
  - fifo_re is never asserted on an empty FIFO.
- Register load: on a grant, pkt_out gets the granted slice, pkt_valid is set to 1, and rr_ptr becomes (grant+1) mod N.
- Drain: if pkt_valid && pkt_ready and there is no grant, pkt_valid is set to 0. pkt_out keeps its value but is don't-care while invalid.
- Count: pkt_cnt increments by 1 on every cycle where pkt_valid && pkt_ready.
- Register states: EMPTY (pkt_valid=0) and FULL (pkt_valid=1).
  - EMPTY to FULL on a grant.
  - FULL to FULL on ready together with a grant (back-to-back), or when ready is low.
  - FULL to EMPTY on ready with no grant.

## Timing
- Reset values: pkt_valid=0, pkt_out=0, rr_ptr=0, pkt_cnt=0.
  - fifo_re is combinational and is 0 whenever pkt_valid=0 and no req is set.
  - Reset is asynchronous, so a packet held in the register is dropped. FIFO contents are not touched.
- fifo_re is a combinational function of fifo_empty, fifo_out, pkt_valid, pkt_ready and rr_ptr, in the same cycle. There is no registered path from the FIFO flags to fifo_re.
- Latency: a packet visible at a FIFO head in cycle t, if granted, appears with pkt_valid=1 in cycle t+1.
- Throughput: one packet per cycle while pkt_ready=1 and requests persist.
- Back-pressure: while pkt_ready=0 and pkt_valid=1:
  - fifo_re stays 0.
  - pkt_out and pkt_valid are held stable.
  - rr_ptr does not move.
- Fairness: with all N requesting continuously, grants cycle i, i+1, …; each input waits at most N-1 grants.
- pkt_cnt wraps from 2^CNTW-1 to 0 with no flag.
- The FIFO's head update takes one edge after fifo_re. The block re-evaluates on the new head in the following cycle without any extra bubble.

## Structure
- The switch shared package or header (sw.vh) provides `PKTW`, `ASSERT`/`NEGATE`, and a new `DSTW` default together with a destination-field extract macro shared with the input side.
- One sub-module, rr_arb: N-bit request vector and pointer in, one-hot grant and valid out. It is purely combinational. rr_ptr and its update live in sw_out_arb.

## Test plan
- Reset mid-packet: with pkt_valid=1, assert rst asynchronously. Required: pkt_valid=0, pkt_cnt=0 and fifo_re=0 immediately, before the next clk edge.
- Single FIFO:
  - Stimulus: FIFO 2 holds 3 packets with dst=PORT_ID and pkt_ready=1.
  - Required: fifo_re[2] is high for 3 consecutive cycles, pkt_valid is high for 3 cycles with the packets in order, and pkt_cnt=3.
- Round-robin:
  - Stimulus: all 4 FIFOs are non-empty and matching, pkt_ready=1, starting from rr_ptr=0.
  - Required: grant order is 0,1,2,3,0.
  - Then FIFO 1 goes empty. Required: the order continues 2,3,0,2.
- Destination filter: FIFO 0 head has dst=PORT_ID+1 and FIFO 3 head has dst=PORT_ID. Required: only fifo_re[3] pulses, and FIFO 0 is never popped.
- Back-pressure:
  - Stimulus: hold pkt_ready=0 for 5 cycles while pkt_valid=1.
  - Required: pkt_out is stable, fifo_re=0, and pkt_cnt is unchanged.
  - Then release pkt_ready. Required: the next packet loads in the same cycle.
- Counter wrap: with CNTW=4, forward 17 packets. Required: pkt_cnt=1.

Source files
------------

// File: rtl/sw_out_arb_pkg.sv
// Shared switch definitions: packet width, destination-field layout and
// the output-register state encoding.
package sw_out_arb_pkg;
  localparam int   PKTW     = 15;
  localparam int   DSTW_DEF = 2;
  localparam logic ASSERT   = 1'b1;
  localparam logic NEGATE   = 1'b0;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} oreg_state_e;

  // Destination field sits in the top dstw bits of a packet.
  function automatic logic [7:0] dst_field(input logic [PKTW:0] pkt, input int dstw);
    return 8'(pkt >> (PKTW + 1 - dstw));
  endfunction
endpackage

// File: rtl/sw_out_arb_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, with wrap.
module rr_arb #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gidx,
  output logic          vld
);
  always_comb begin
    gnt  = '0;
    gidx = '0;
    vld  = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!vld && req[idx]) begin
        vld       = 1'b1;
        gnt[idx]  = 1'b1;
        gidx      = PW'(idx);
      end
    end
  end
endmodule

// File: rtl/sw_out_arb.sv
// Output-port reader: round-robin drains matching FIFO heads into a
// one-entry valid/ready output register and counts forwarded packets.
module sw_out_arb
  import sw_out_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int PORT_ID = 0,
  parameter int DSTW    = DSTW_DEF,
  parameter int CNTW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*(PKTW+1)-1:0] fifo_out,
  input  logic [N-1:0]        fifo_empty,
  output logic [N-1:0]        fifo_re,
  output logic [PKTW:0]       pkt_out,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic [CNTW-1:0]     pkt_cnt
);
  localparam int PW = $clog2(N);

  oreg_state_e   state;
  logic [N-1:0]  req, gnt;
  logic [PW-1:0] rr_ptr, gidx;
  logic          gvld, load_ok;

  assign pkt_valid = (state == FULL);
  assign load_ok   = !pkt_valid || pkt_ready;

  for (genvar i = 0; i < N; i++) begin : g_req
    assign req[i] = !fifo_empty[i] &&
                    (dst_field(fifo_out[i*(PKTW+1) +: PKTW+1], DSTW) == 8'(PORT_ID));
  end

  // Requests are masked by load_ok so a stalled register never pops a FIFO.
  rr_arb #(.N(N), .PW(PW)) u_arb (
    .req  (req & {N{load_ok}}),
    .ptr  (rr_ptr),
    .gnt  (gnt),
    .gidx (gidx),
    .vld  (gvld)
  );

  assign fifo_re = rst ? '0 : gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      pkt_out <= '0;
      rr_ptr  <= '0;
      pkt_cnt <= '0;
    end else begin
      if (pkt_valid && pkt_ready) pkt_cnt <= pkt_cnt + 1'b1;
      if (gvld) begin
        pkt_out <= fifo_out[int'(gidx)*(PKTW+1) +: PKTW+1];
        rr_ptr  <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
      end
      case (state)
        EMPTY:   if (gvld) state <= FULL;
        FULL:    if (pkt_ready && !gvld) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_sw_out_arb.sv
// Scoreboard bench for sw_out_arb with a behavioural FIFO model per input.
module tb_sw_out_arb;
  import sw_out_arb_pkg::*;
  localparam int N = 4, PW = PKTW + 1, CNTW = 4;

  logic            clk = 1'b0, rst = 1'b1;
  logic [N*PW-1:0] fifo_out;
  logic [N-1:0]    fifo_empty, fifo_re, re_s;
  logic [PW-1:0]   pkt_out;
  logic            pkt_valid, pkt_ready;
  logic [CNTW-1:0] pkt_cnt;

  logic [PW-1:0] fq[N][$];
  logic [PW-1:0] exp_q[$];
  int checks = 0, failures = 0, re2_cnt = 0;

  sw_out_arb #(.N(N), .PORT_ID(0), .DSTW(2), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
    .fifo_re(fifo_re), .pkt_out(pkt_out), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input int dst, input int tag);
    return {2'(dst), 14'(tag)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_out[i*PW +: PW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    chk(nm, exp_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; #1;
    tick();
    rst = 1'b0;
  endtask

  // FIFO model: pop on the edge after a strobe sampled mid-cycle.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (re_s[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    refresh();
  end

  // Monitor: strobe legality against the model, packets against the scoreboard.
  always @(negedge clk) begin
    logic [N-1:0]  req_m;
    logic [PW-1:0] h, e;
    re_s = fifo_re;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        h = (fq[i].size() != 0) ? fq[i][0] : '0;
        req_m[i] = (fq[i].size() != 0) && (h[PW-1 -: 2] == 2'd0);
      end
      if (fifo_re != 0) chk("re_legal", {28'd0, fifo_re & ~req_m}, 0);
      if (fifo_re[2]) re2_cnt++;
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pkt", {16'd0, pkt_out}, 32'hFFFF_FFFF);
        else begin e = exp_q.pop_front(); chk("pkt", {16'd0, pkt_out}, {16'd0, e}); end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_ready = 1'b0; re_s = '0;
    refresh();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_valid", pkt_valid, 0);
    chk("rst_out", pkt_out, 0);
    chk("rst_cnt", pkt_cnt, 0);
    chk("rst_re", fifo_re, 0);

    // Single FIFO: three packets in order, three strobes.
    re2_cnt = 0;
    for (int k = 0; k < 3; k++) begin fq[2].push_back(mk(0, 'h20 + k)); exp_q.push_back(mk(0, 'h20 + k)); end
    refresh(); pkt_ready = 1'b1;
    drain("single_drain");
    chk("single_re2", re2_cnt, 3);
    chk("single_cnt", pkt_cnt, 3);

    // Asynchronous reset with a packet held in the register.
    pkt_ready = 1'b0;
    fq[0].push_back(mk(0, 'h01)); refresh();
    tick(); tick();
    chk("pre_rst_valid", pkt_valid, 1);
    fq[1].push_back(mk(0, 'h11)); refresh();
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", pkt_valid, 0);
    chk("async_rst_cnt", pkt_cnt, 0);
    chk("async_rst_re", fifo_re, 0);
    tick();
    exp_q.push_back(mk(0, 'h11));
    rst = 1'b0; pkt_ready = 1'b1;
    drain("post_rst_drain");
    chk("post_rst_cnt", pkt_cnt, 1);

    // Round robin: 0,1,2,3,0 then FIFO 1 empty -> 2,3,0,2.
    do_reset();
    pkt_ready = 1'b0;
    for (int k = 0; k < 3; k++) fq[0].push_back(mk(0, 'h100 + k));
    fq[1].push_back(mk(0, 'h110));
    for (int k = 0; k < 3; k++) fq[2].push_back(mk(0, 'h120 + k));
    for (int k = 0; k < 2; k++) fq[3].push_back(mk(0, 'h130 + k));
    exp_q.push_back(mk(0, 'h100)); exp_q.push_back(mk(0, 'h110));
    exp_q.push_back(mk(0, 'h120)); exp_q.push_back(mk(0, 'h130));
    exp_q.push_back(mk(0, 'h101)); exp_q.push_back(mk(0, 'h121));
    exp_q.push_back(mk(0, 'h131)); exp_q.push_back(mk(0, 'h102));
    exp_q.push_back(mk(0, 'h122));
    refresh(); pkt_ready = 1'b1;
    drain("rr_drain");
    chk("rr_cnt", pkt_cnt, 9);

    // Destination filter: FIFO 0 head belongs to another port.
    fq[0].push_back(mk(1, 'h05));
    fq[3].push_back(mk(0, 'h35));
    exp_q.push_back(mk(0, 'h35));
    refresh();
    drain("filter_drain");
    chk("filter_fifo0_kept", fq[0].size(), 1);
    fq[0].delete(); refresh();

    // Back-pressure: register held, no pops, count frozen; release loads at once.
    do_reset();
    pkt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin fq[2].push_back(mk(0, 'h220 + k)); exp_q.push_back(mk(0, 'h220 + k)); end
    refresh();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_out", pkt_out, mk(0, 'h220));
      chk("bp_valid", pkt_valid, 1);
      chk("bp_re", fifo_re, 0);
      chk("bp_cnt", pkt_cnt, 0);
      tick();
    end
    pkt_ready = 1'b1;
    #1 chk("bp_release_re", fifo_re, 4'b0100);
    drain("bp_drain");
    chk("bp_cnt_final", pkt_cnt, 3);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int k = 0; k < 17; k++) begin fq[1].push_back(mk(0, 'h300 + k)); exp_q.push_back(mk(0, 'h300 + k)); end
    refresh();
    drain("wrap_drain");
    chk("wrap_cnt", pkt_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
